// File: rtl/rv32i_clint_bridge_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_clint_bridge_pkg
// Shared definitions for the CLINT-style bus bridge: window geometry, word
// indices of the register map (byte offset >> 2), FSM state encoding and a
// helper that says whether a word index is backed by a real register.
//
// Optional build macro: CLINT_BUS_ERROR_EN (adds the error counter at 0x18).
// ---------------------------------------------------------------------------
package rv32i_clint_bridge_pkg;

  localparam int WINDOW_BYTES = 32;
  localparam int WINDOW_LSB   = 5;    // log2(WINDOW_BYTES)

  // Word indices inside the window (byte offset / 4)
  localparam logic [2:0] IDX_MSIP        = 3'd0;  // 0x00
  localparam logic [2:0] IDX_MTIMECMP_LO = 3'd2;  // 0x08
  localparam logic [2:0] IDX_MTIMECMP_HI = 3'd3;  // 0x0C
  localparam logic [2:0] IDX_MTIME_LO    = 3'd4;  // 0x10
  localparam logic [2:0] IDX_MTIME_HI    = 3'd5;  // 0x14
  localparam logic [2:0] IDX_ERRCNT      = 3'd6;  // 0x18 (optional)

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // True when the word index maps to an implemented register.
  function automatic logic is_mapped(input logic [2:0] idx);
    logic mapped;
    case (idx)
      IDX_MSIP, IDX_MTIMECMP_LO, IDX_MTIMECMP_HI,
      IDX_MTIME_LO, IDX_MTIME_HI: mapped = 1'b1;
`ifdef CLINT_BUS_ERROR_EN
      IDX_ERRCNT:                 mapped = 1'b1;
`endif
      default:                    mapped = 1'b0;
    endcase
    return mapped;
  endfunction

endpackage

// File: rtl/rv32i_clint_reg64.sv
// ---------------------------------------------------------------------------
// rv32i_clint_reg64
// 64-bit shadow register written as two 32-bit halves. A LO write is staged
// (byte-merged into the staging word) and marks the register pending; a HI
// write commits {merged_hi, pending ? staged_lo : current_lo} with a
// one-cycle commit pulse and clears pending. A LO write that is never
// followed by a HI write never reaches the shadow.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_lo, wr_hi     one-cycle write strobes for the LO / HI half
//   wdata, wmask     store data and byte enables
//   shadow_lo/hi     last committed value (read-back)
//   commit           one-cycle pulse, same cycle as the bus acknowledge
//   din              committed value, held between pulses
// ---------------------------------------------------------------------------
module rv32i_clint_reg64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic [31:0] shadow_lo,
  output logic [31:0] shadow_hi,
  output logic        commit,
  output logic [63:0] din
);

  logic [31:0] staged_lo_reg;
  logic        pending_reg;
  logic [31:0] lo_current;
  logic [31:0] lo_merged;
  logic [31:0] hi_merged;

  // A second LO write before the HI write merges on top of the staged word.
  assign lo_current = pending_reg ? staged_lo_reg : shadow_lo;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign lo_merged[8*gi +: 8] = wmask[gi] ? wdata[8*gi +: 8] : lo_current[8*gi +: 8];
    assign hi_merged[8*gi +: 8] = wmask[gi] ? wdata[8*gi +: 8] : shadow_hi[8*gi +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged_lo_reg <= '0;
      pending_reg   <= 1'b0;
      shadow_lo     <= '0;
      shadow_hi     <= '0;
      commit        <= 1'b0;
      din           <= '0;
    end else begin
      commit <= wr_hi;
      if (wr_lo) begin
        staged_lo_reg <= lo_merged;
        pending_reg   <= 1'b1;
      end else if (wr_hi) begin
        shadow_hi   <= hi_merged;
        shadow_lo   <= lo_current;
        din         <= {hi_merged, lo_current};
        pending_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rv32i_clint_bridge.sv
// ---------------------------------------------------------------------------
// rv32i_clint_bridge
// Memory-mapped CLINT-style responder on the core data bus. Decodes 32-bit
// loads/stores into a 32-byte window at BASE_ADDR and drives the SoC timer /
// software-interrupt inputs. Every hit is acknowledged exactly one cycle
// after the strobe; misses are ignored.
//
// Map: 0x00 MSIP(bit0)  0x08/0x0C MTIMECMP lo/hi  0x10/0x14 MTIME lo/hi
//      0x18 error counter (only with CLINT_BUS_ERROR_EN), others reserved.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_stb, i_wr_en          request strobe, 1 = store
//   i_addr, i_data_in       byte address, store data
//   i_wr_mask               store byte enables
//   o_ack, o_data_out       response strobe, load data (0 when no ack)
//   o_mtime_wr/_din         mtime commit pulse and held value
//   o_mtimecmp_wr/_din      mtimecmp commit pulse and held value
//   o_software_interrupt    msip level
//   o_bus_err               (CLINT_BUS_ERROR_EN) error flag with o_ack
//
// Optional macro: CLINT_BUS_ERROR_EN.
// ---------------------------------------------------------------------------
module rv32i_clint_bridge
  import rv32i_clint_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1F00,
  parameter int          CLK_FREQ_MHZ = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_wr_mask,
  output logic        o_ack,
  output logic [31:0] o_data_out,
  output logic        o_mtime_wr,
  output logic [63:0] o_mtime_din,
  output logic        o_mtimecmp_wr,
  output logic [63:0] o_mtimecmp_din,
  output logic        o_software_interrupt
`ifdef CLINT_BUS_ERROR_EN
  ,
  output logic        o_bus_err
`endif
);

  localparam int PRESC_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ_MHZ - 1);

  state_t       state_reg;
  logic         ack_reg;
  logic         wr_reg;
  logic [2:0]   idx_reg;
  logic         msip_wr_reg;
  logic         msip_val_reg;
  logic         msip_reg;

  logic         hit;
  logic         accept;
  logic [2:0]   idx;

  logic [31:0]  cmp_lo, cmp_hi, time_lo, time_hi;
  logic [PRESC_W-1:0] presc_reg;
  logic [63:0]  mirror_reg;
  logic [31:0]  rd_word;

  assign hit    = (i_addr[31:WINDOW_LSB] == BASE_ADDR[31:WINDOW_LSB]) && (i_addr[1:0] == 2'b00);
  assign idx    = i_addr[4:2];
  // Strobes arriving in RESP are dropped: only IDLE accepts.
  assign accept = (state_reg == ST_IDLE) && i_stb && hit;

  // Request FSM. Register writes are launched on the accepting edge so the
  // commit pulse and data land in the acknowledge cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= ST_IDLE;
      ack_reg      <= 1'b0;
      wr_reg       <= 1'b0;
      idx_reg      <= '0;
      msip_wr_reg  <= 1'b0;
      msip_val_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg    <= ST_RESP;
            ack_reg      <= 1'b1;
            wr_reg       <= i_wr_en;
            idx_reg      <= idx;
            msip_wr_reg  <= i_wr_en && (idx == IDX_MSIP) && i_wr_mask[0];
            msip_val_reg <= i_data_in[0];
          end
        end
        ST_RESP: begin
          state_reg   <= ST_IDLE;
          ack_reg     <= 1'b0;
          msip_wr_reg <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // msip changes at the end of the acknowledge cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      msip_reg <= 1'b0;
    end else if (msip_wr_reg) begin
      msip_reg <= msip_val_reg;
    end
  end

  rv32i_clint_reg64 u_mtimecmp (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .wr_lo     (accept && i_wr_en && (idx == IDX_MTIMECMP_LO)),
    .wr_hi     (accept && i_wr_en && (idx == IDX_MTIMECMP_HI)),
    .wdata     (i_data_in),
    .wmask     (i_wr_mask),
    .shadow_lo (cmp_lo),
    .shadow_hi (cmp_hi),
    .commit    (o_mtimecmp_wr),
    .din       (o_mtimecmp_din)
  );

  rv32i_clint_reg64 u_mtime (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .wr_lo     (accept && i_wr_en && (idx == IDX_MTIME_LO)),
    .wr_hi     (accept && i_wr_en && (idx == IDX_MTIME_HI)),
    .wdata     (i_data_in),
    .wmask     (i_wr_mask),
    .shadow_lo (time_lo),
    .shadow_hi (time_hi),
    .commit    (o_mtime_wr),
    .din       (o_mtime_din)
  );

  // 1 us mirror of mtime. A commit takes priority over a coincident tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_reg  <= '0;
      mirror_reg <= '0;
    end else if (o_mtime_wr) begin
      presc_reg  <= '0;
      mirror_reg <= o_mtime_din;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg  <= '0;
      mirror_reg <= mirror_reg + 64'd1;
    end else begin
      presc_reg  <= presc_reg + 1'b1;
    end
  end

`ifdef CLINT_BUS_ERROR_EN
  logic       err_reg;
  logic [7:0] err_cnt_reg;
  logic       req_err;

  assign req_err = !is_mapped(idx) || (i_wr_en && (i_wr_mask == 4'b0000));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
    end else begin
      err_reg <= accept && req_err;
      if (accept && req_err && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign o_bus_err = err_reg;
`endif

  // Load data mux; the MTIME words read the running mirror, not the shadow.
  always_comb begin
    rd_word = '0;
    case (idx_reg)
      IDX_MSIP:        rd_word = {31'b0, msip_reg};
      IDX_MTIMECMP_LO: rd_word = cmp_lo;
      IDX_MTIMECMP_HI: rd_word = cmp_hi;
      IDX_MTIME_LO:    rd_word = mirror_reg[31:0];
      IDX_MTIME_HI:    rd_word = mirror_reg[63:32];
`ifdef CLINT_BUS_ERROR_EN
      IDX_ERRCNT:      rd_word = {24'b0, err_cnt_reg};
`endif
      default:         rd_word = '0;
    endcase
  end

  assign o_ack                = ack_reg;
  assign o_data_out           = (ack_reg && !wr_reg) ? rd_word : 32'h0;
  assign o_software_interrupt = msip_reg;

  // The mtime shadow words only feed the commit path; reads use the mirror.
  logic unused_shadow;
  assign unused_shadow = ^{time_lo, time_hi};

endmodule

// File: tb/tb_rv32i_clint_bridge.sv
// ---------------------------------------------------------------------------
// tb_rv32i_clint_bridge
// Self-checking bench for rv32i_clint_bridge: directed scenarios followed by
// randomized loads/stores checked against a register-level model of the
// CLINT window (shadows, staged LO words, msip, a time-based mtime mirror).
// ---------------------------------------------------------------------------
module tb_rv32i_clint_bridge;

  localparam logic [31:0] BASE = 32'h0000_1F00;
  localparam int          FREQ = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        mtime_wr;
  logic [63:0] mtime_din;
  logic        mtimecmp_wr;
  logic [63:0] mtimecmp_din;
  logic        swi;
`ifdef CLINT_BUS_ERROR_EN
  logic        bus_err;
`endif

  rv32i_clint_bridge #(.BASE_ADDR(BASE), .CLK_FREQ_MHZ(FREQ)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_stb               (stb),
    .i_wr_en             (wr_en),
    .i_addr              (addr),
    .i_data_in           (wdata),
    .i_wr_mask           (mask),
    .o_ack               (ack),
    .o_data_out          (rdata),
    .o_mtime_wr          (mtime_wr),
    .o_mtime_din         (mtime_din),
    .o_mtimecmp_wr       (mtimecmp_wr),
    .o_mtimecmp_din      (mtimecmp_din),
    .o_software_interrupt(swi)
`ifdef CLINT_BUS_ERROR_EN
    ,
    .o_bus_err           (bus_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Captured response of one transaction
  logic        r_ack, r_ack2, r_pulse2, r_msip, r_msip_resp, r_mwr, r_cwr, r_err;
  logic [31:0] r_data;
  logic [63:0] r_mdin, r_cdin;
  int unsigned r_cyc;

  // Reference model state
  logic        m_msip;
  logic [31:0] m_cmp_lo, m_cmp_hi, m_cmp_st;
  logic        m_cmp_pend;
  logic [31:0] m_tim_lo, m_tim_hi, m_tim_st;
  logic        m_tim_pend;
  logic [63:0] m_mir_base;
  int unsigned m_mir_cyc;
  int          m_errcnt;

  function automatic logic [31:0] mrg(input logic [31:0] old_w, input logic [31:0] new_w,
                                      input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // Mirror value after posedge number c: base + whole microseconds elapsed.
  function automatic logic [63:0] mirror_at(input int unsigned c);
    return m_mir_base + 64'((c - m_mir_cyc) / FREQ);
  endfunction

  task automatic reset_model();
    m_msip = 0; m_cmp_lo = 0; m_cmp_hi = 0; m_cmp_st = 0; m_cmp_pend = 0;
    m_tim_lo = 0; m_tim_hi = 0; m_tim_st = 0; m_tim_pend = 0;
    m_mir_base = 0; m_errcnt = 0;
    m_mir_cyc = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  // One bus request: strobe for one cycle, sample the response cycle and the
  // cycle after it.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] m);
    @(negedge clk);
    stb = 1'b1; wr_en = w; addr = a; wdata = d; mask = m;
    @(posedge clk); #1;
    stb = 1'b0; wr_en = 1'b0;
    r_ack = ack; r_data = rdata; r_mwr = mtime_wr; r_mdin = mtime_din;
    r_cwr = mtimecmp_wr; r_cdin = mtimecmp_din; r_msip_resp = swi; r_cyc = cyc;
`ifdef CLINT_BUS_ERROR_EN
    r_err = bus_err;
`else
    r_err = 1'b0;
`endif
    @(posedge clk); #1;
    r_ack2 = ack; r_pulse2 = mtime_wr | mtimecmp_wr; r_msip = swi;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({ack, mtime_wr, mtimecmp_wr, swi} !== 4'b0) begin bad++;
      $display("FAIL reset_strobes got=%b want=0000", {ack, mtime_wr, mtimecmp_wr, swi}); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", rdata); end
    total++; if ({mtime_din, mtimecmp_din} !== 128'h0) begin bad++;
      $display("FAIL reset_din got=%h/%h want=0", mtime_din, mtimecmp_din); end
    rst_n = 1'b1;
    reset_model();
    @(posedge clk); #1;
    total++; if ({ack, swi} !== 2'b0) begin bad++; $display("FAIL post_reset got=%b want=00", {ack, swi}); end
    $display("reset: released, outputs idle");
  endtask

  task automatic test_mtimecmp_commit();
    bus(1'b1, BASE + 32'h08, 32'h0000_000F, 4'hF);
    total++; if ({r_ack, r_cwr} !== 2'b10) begin bad++;
      $display("FAIL cmp_lo_store ack/wr got=%b want=10", {r_ack, r_cwr}); end
    bus(1'b1, BASE + 32'h0C, 32'h0, 4'hF);
    total++; if ({r_ack, r_cwr, r_pulse2} !== 3'b110) begin bad++;
      $display("FAIL cmp_hi_commit ack/wr/wr_next got=%b want=110", {r_ack, r_cwr, r_pulse2}); end
    total++; if (r_cdin !== 64'h0000_0000_0000_000F) begin bad++;
      $display("FAIL cmp_din got=%h want=000000000000000f", r_cdin); end
    $display("mtimecmp commit: din=%h", r_cdin);
  endtask

  task automatic test_msip();
    bus(1'b1, BASE, 32'h1, 4'hF);
    total++; if ({r_ack, r_msip_resp, r_msip} !== 3'b101) begin bad++;
      $display("FAIL msip_set ack/resp/after got=%b want=101", {r_ack, r_msip_resp, r_msip}); end
    bus(1'b1, BASE, 32'h0, 4'hF);
    total++; if (r_msip !== 1'b0) begin bad++; $display("FAIL msip_clear got=%b want=0", r_msip); end
    bus(1'b0, BASE, 32'h0, 4'h0);
    total++; if ({r_ack, r_data} !== {1'b1, 32'h0}) begin bad++;
      $display("FAIL msip_load got=%b/%h want=1/00000000", r_ack, r_data); end
    $display("msip: set/clear/read done");
  endtask

  task automatic test_hi_only();
    bus(1'b1, BASE + 32'h0C, 32'h1234_5678, 4'b0010);
    total++; if ({r_cwr, r_pulse2} !== 2'b10) begin bad++;
      $display("FAIL hi_only_pulse got=%b want=10", {r_cwr, r_pulse2}); end
    total++; if (r_cdin !== 64'h0000_5600_0000_000F) begin bad++;
      $display("FAIL hi_only_din got=%h want=000056000000000f", r_cdin); end
    $display("hi-only store: din=%h", r_cdin);
  endtask

  task automatic test_wrap();
    bus(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'hF);
    bus(1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    total++; if ({r_mwr, r_mdin} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin bad++;
      $display("FAIL wrap_commit got=%b/%h want=1/ffffffffffffffff", r_mwr, r_mdin); end
    repeat (FREQ) @(posedge clk);
    bus(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL wrap_lo got=%h want=0", r_data); end
    bus(1'b0, BASE + 32'h14, 32'h0, 4'h0);
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h want=0", r_data); end
    $display("mtime wrap: mirror read back as zero");
  endtask

  task automatic test_reset_abort();
    bus(1'b1, BASE + 32'h10, 32'hAAAA_5555, 4'hF);
    do_reset();
    bus(1'b1, BASE + 32'h14, 32'h0000_0001, 4'hF);
    total++; if ({r_mwr, r_mdin} !== {1'b1, 64'h0000_0001_0000_0000}) begin bad++;
      $display("FAIL staging_lost got=%b/%h want=1/0000000100000000", r_mwr, r_mdin); end
    // Reset during the response cycle kills the ack and the pulse at once.
    @(negedge clk);
    stb = 1'b1; wr_en = 1'b1; addr = BASE + 32'h0C; wdata = 32'h7; mask = 4'hF;
    @(posedge clk); #1;
    stb = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if ({ack, mtimecmp_wr} !== 2'b00) begin bad++;
      $display("FAIL abort got=%b want=00", {ack, mtimecmp_wr}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    $display("reset abort: staging dropped, in-flight response killed");
  endtask

  task automatic test_reserved();
    bus(1'b0, BASE + 32'h04, 32'h0, 4'h0);
    total++; if ({r_ack, r_data} !== {1'b1, 32'h0}) begin bad++;
      $display("FAIL reserved_load got=%b/%h want=1/00000000", r_ack, r_data); end
    bus(1'b0, BASE + 32'h40, 32'h0, 4'h0);
    total++; if ({r_ack, r_ack2} !== 2'b00) begin bad++;
      $display("FAIL miss_ack got=%b want=00", {r_ack, r_ack2}); end
    bus(1'b1, BASE + 32'h0E, 32'h0, 4'hF);
    total++; if ({r_ack, r_ack2, r_cwr} !== 3'b000) begin bad++;
      $display("FAIL unaligned got=%b want=000", {r_ack, r_ack2, r_cwr}); end
    $display("reserved/miss decode done");
  endtask

  task automatic test_back_to_back();
    logic a1, a2, a3;
    @(negedge clk);
    stb = 1'b1; wr_en = 1'b1; addr = BASE; wdata = 32'h1; mask = 4'hF;
    @(posedge clk); #1;
    a1 = ack;
    wdata = 32'h0;                 // second strobe lands in RESP: dropped
    @(posedge clk); #1;
    a2 = ack;
    stb = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    a3 = ack;
    total++; if ({a1, a2, a3} !== 3'b100) begin bad++;
      $display("FAIL b2b_ack got=%b want=100", {a1, a2, a3}); end
    total++; if (swi !== 1'b1) begin bad++; $display("FAIL b2b_msip got=%b want=1", swi); end
    $display("back-to-back: second strobe dropped");
  endtask

`ifdef CLINT_BUS_ERROR_EN
  task automatic test_bus_err();
    do_reset();
    bus(1'b0, BASE + 32'h04, 32'h0, 4'h0);
    total++; if ({r_ack, r_err} !== 2'b11) begin bad++;
      $display("FAIL err_flag got=%b want=11", {r_ack, r_err}); end
    bus(1'b0, BASE + 32'h18, 32'h0, 4'h0);
    total++; if ({r_err, r_data} !== {1'b0, 32'h1}) begin bad++;
      $display("FAIL err_count got=%b/%h want=0/00000001", r_err, r_data); end
    $display("bus error: flag and counter checked");
  endtask
`endif

  task automatic test_random();
    logic        w, hit, mapped, e_mwr, e_cwr, e_err;
    logic [31:0] a, d, e_data, hi, lo;
    logic [3:0]  m;
    logic [2:0]  off;
    logic [63:0] e_mdin, e_cdin;
    int          sel;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 20)) @(posedge clk);
      sel = $urandom_range(0, 9);
      off = 3'($urandom_range(0, 7));
      a = BASE + {27'b0, off, 2'b00};
      if (sel == 0) a = a + 32'($urandom_range(1, 3));
      else if (sel == 1) a = BASE + 32'h20 + 32'($urandom_range(0, 255) * 4);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      bus(w, a, d, m);

      hit = (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
      e_data = 0; e_mwr = 0; e_cwr = 0; e_err = 0; e_mdin = 0; e_cdin = 0;
      if (hit) begin
        mapped = off inside {3'd0, 3'd2, 3'd3, 3'd4, 3'd5};
`ifdef CLINT_BUS_ERROR_EN
        mapped = mapped || (off == 3'd6);
`endif
        e_err = !mapped || (w && (m == 4'b0));
        if (!w) begin
          case (off)
            3'd0: e_data = {31'b0, m_msip};
            3'd2: e_data = m_cmp_lo;
            3'd3: e_data = m_cmp_hi;
            3'd4: e_data = mirror_at(r_cyc) & 64'hFFFF_FFFF;
            3'd5: e_data = mirror_at(r_cyc) >> 32;
`ifdef CLINT_BUS_ERROR_EN
            3'd6: e_data = 32'(m_errcnt);
`endif
            default: e_data = 0;
          endcase
        end else begin
          case (off)
            3'd0: if (m[0]) m_msip = d[0];
            3'd2: begin m_cmp_st = mrg(m_cmp_pend ? m_cmp_st : m_cmp_lo, d, m); m_cmp_pend = 1; end
            3'd3: begin
              hi = mrg(m_cmp_hi, d, m); lo = m_cmp_pend ? m_cmp_st : m_cmp_lo;
              e_cwr = 1; e_cdin = {hi, lo}; m_cmp_hi = hi; m_cmp_lo = lo; m_cmp_pend = 0;
            end
            3'd4: begin m_tim_st = mrg(m_tim_pend ? m_tim_st : m_tim_lo, d, m); m_tim_pend = 1; end
            3'd5: begin
              hi = mrg(m_tim_hi, d, m); lo = m_tim_pend ? m_tim_st : m_tim_lo;
              e_mwr = 1; e_mdin = {hi, lo}; m_tim_hi = hi; m_tim_lo = lo; m_tim_pend = 0;
              m_mir_base = {hi, lo}; m_mir_cyc = r_cyc + 1;
            end
            default: ;
          endcase
        end
        if (e_err && m_errcnt != 255) m_errcnt++;
      end

      total++; if ({r_ack, r_ack2, r_pulse2} !== {hit, 2'b00}) begin bad++;
        $display("FAIL rnd_ack n=%0d addr=%h got=%b want=%b00", n, a, {r_ack, r_ack2, r_pulse2}, hit); end
      total++; if (r_data !== e_data) begin bad++;
        $display("FAIL rnd_data n=%0d addr=%h got=%h want=%h", n, a, r_data, e_data); end
      total++; if ({r_mwr, r_cwr} !== {e_mwr, e_cwr}) begin bad++;
        $display("FAIL rnd_pulse n=%0d addr=%h got=%b want=%b", n, a, {r_mwr, r_cwr}, {e_mwr, e_cwr}); end
      if (e_mwr) begin
        total++; if (r_mdin !== e_mdin) begin bad++;
          $display("FAIL rnd_mtime_din n=%0d got=%h want=%h", n, r_mdin, e_mdin); end
      end
      if (e_cwr) begin
        total++; if (r_cdin !== e_cdin) begin bad++;
          $display("FAIL rnd_cmp_din n=%0d got=%h want=%h", n, r_cdin, e_cdin); end
      end
      total++; if (r_msip !== m_msip) begin bad++;
        $display("FAIL rnd_msip n=%0d got=%b want=%b", n, r_msip, m_msip); end
`ifdef CLINT_BUS_ERROR_EN
      total++; if (r_err !== e_err) begin bad++;
        $display("FAIL rnd_err n=%0d addr=%h got=%b want=%b", n, a, r_err, e_err); end
`endif
      $display("rnd %0d: %s addr=%h data=%h mask=%b ack=%b rdata=%h",
               n, w ? "st" : "ld", a, d, m, r_ack, r_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_model();
    test_reset();
    test_mtimecmp_commit();
    test_msip();
    test_hi_only();
    test_wrap();
    test_reset_abort();
    test_reserved();
    test_back_to_back();
`ifdef CLINT_BUS_ERROR_EN
    test_bus_err();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_clint_bridge.md
Name: rv32i_clint_bridge

Overview:
- Memory-mapped timer/software-interrupt responder on the core data bus.
- Decodes 32-bit loads and stores to a small CLINT-style register window.
- Drives the SoC timer/software interrupt inputs: 64-bit mtime/mtimecmp write pulses plus data, and the msip level.
- Replaces testbench-forced interrupt stimulus with software-controlled stimulus.

Parameters:
- BASE_ADDR, 32'h0000_1F00: word-aligned base of the 32-byte register window.
- CLK_FREQ_MHZ, 100: clock cycles per 1 us mtime tick, for the mirror counter.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stb  in  1  bus request strobe, one cycle per request
- i_wr_en  in  1  1 = store, 0 = load
- i_addr  in  32  byte address
- i_data_in  in  32  store data
- i_wr_mask  in  4  byte enables for stores
- o_ack  out  1  one-cycle response strobe
- o_data_out  out  32  load data, valid when o_ack = 1
- o_mtime_wr  out  1  one-cycle pulse to the SoC i_mtime_wr
- o_mtime_din  out  64  value for mtime, held between pulses
- o_mtimecmp_wr  out  1  one-cycle pulse to the SoC i_mtimecmp_wr
- o_mtimecmp_din  out  64  value for mtimecmp, held between pulses
- o_software_interrupt  out  1  msip level to the SoC i_software_interrupt

Behaviour:
- Clock and reset: i_clk is the only clock. Reset is asynchronous, active-low on i_rst_n.
- Reset values: all outputs 0, all shadows 0, both pending flags 0, mirror 0, FSM in IDLE.
- Register map (byte offsets from BASE_ADDR): 0x00 MSIP (bit0 only), 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 MTIME_LO, 0x14 MTIME_HI. All other offsets are reserved.
- Hit condition: i_addr[31:5] == BASE_ADDR[31:5] and i_addr[1:0] == 0. Requests that miss the window are ignored (no ack).
- FSM states IDLE and RESP:
  - IDLE -> RESP on i_stb with a hit. Address, data, mask and i_wr_en are latched.
  - RESP -> IDLE unconditionally. o_ack = 1 for exactly that cycle, giving a fixed 1-cycle latency.
  - A new i_stb arriving in RESP is a protocol violation and is dropped.
- Stores (applied in the RESP cycle):
  - Byte-masked merge into the addressed shadow word.
  - LO write: sets the pending flag for that register.
  - HI write: in the same cycle as o_ack,
    - drives o_*_din = {merged_hi, pending ? staged_lo : current_lo},
    - pulses o_*_wr high for one cycle,
    - clears the pending flag.
  - LO write with no later HI write: never commits.
  - MSIP write: bit0 updates o_software_interrupt, effective the cycle after o_ack.
  - Reserved offset: acknowledged, write discarded.
- Loads: o_data_out is the shadow or mirror value in the RESP cycle, 0 for reserved offsets. o_data_out is 0 whenever o_ack = 0.
- mtime mirror:
  - A 1 us prescaler (counts 0..CLK_FREQ_MHZ-1) increments a 64-bit mirror with modulo-2^64 wrap.
  - On an MTIME commit, the mirror loads the committed value and the prescaler clears in the same cycle.
  - MTIME_LO/HI loads return the mirror.
- Reset mid-transaction aborts: no ack, no pulse, pending flags cleared.
- Simultaneous mirror tick and MTIME commit: the commit wins.

Optional Feature:
- Macro: CLINT_BUS_ERROR_EN.
- When defined:
  - Adds output o_bus_err (1 bit), asserted together with o_ack for a reserved offset or for a store with i_wr_mask == 0.
  - Adds a sticky 8-bit saturating error counter, readable at offset 0x18.
- When undefined: no port, no counter; offset 0x18 is reserved (reads 0).

Decomposition:
- Shared package/header (rv32i_header.vh style): register offset localparams, FSM state encodings, window size.
- One sub-module, rv32i_clint_reg64: a 64-bit shadow with LO staging, pending flag, byte merge and commit pulse. It is instantiated twice (mtime, mtimecmp). The mtime instance also receives the mirror load.

Test Plan:
- Store 0x0000000F to 0x08, then 0x0 to 0x0C -> o_mtimecmp_wr is one cycle high on the second ack, o_mtimecmp_din = 64'h0000_0000_0000_000F. No pulse on the first store.
- Store 1 to 0x00 -> o_software_interrupt = 1 the cycle after ack. Store 0 -> returns to 0. Load 0x00 -> 0x00000000.
- Store 0x12345678 to 0x0C with i_wr_mask = 4'b0010, no prior LO write -> o_mtimecmp_din[63:32] = 0x00005600, low word = previous shadow, one pulse.
- Commit mtime = 0xFFFFFFFF_FFFFFFFF, wait CLK_FREQ_MHZ cycles -> load 0x10 and 0x14 both return 0 (wrap).
- Store LO to 0x10, assert i_rst_n = 0 for 2 cycles, store HI to 0x14 -> o_mtime_din low word = 0 (staging lost).
- Load 0x04 -> o_ack, data 0. Load BASE_ADDR+0x40 -> no ack.
- With CLINT_BUS_ERROR_EN defined: load 0x04 -> o_bus_err with o_ack, and 0x18 reads 1.
